// File: rtl/iqueue_mw.sv
// iqueue_mw: multi-wide instruction queue between fetch/decode and dispatch.
// Accepts up to ENQ_W entries per cycle (all-or-nothing) and presents the
// oldest DEQ_W entries on a show-ahead read port. Flush empties the queue in
// one cycle.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   flush      discard all contents (wins over same-cycle enq/deq)
//   enq_valid  per-lane valid, contiguous from lane 0
//   enq_data   lane i at [i*DATA_W +: DATA_W]
//   enq_ready  room for a full ENQ_W-wide group (pre-dequeue count)
//   deq_valid  lane i holds a live entry
//   deq_data   lane 0 is the oldest entry, combinational from storage
//   deq_take   consume lanes, contiguous from lane 0
//   count      current occupancy
//   full/empty count == DEPTH / count == 0
module iqueue_mw #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 96,
    parameter int unsigned ENQ_W  = 2,
    parameter int unsigned DEQ_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [ENQ_W-1:0]          enq_valid,
    input  logic [ENQ_W*DATA_W-1:0]   enq_data,
    output logic                      enq_ready,
    output logic [DEQ_W-1:0]          deq_valid,
    output logic [DEQ_W*DATA_W-1:0]   deq_data,
    input  logic [DEQ_W-1:0]          deq_take,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  n_enq;
    logic [PTR_W-1:0]  n_enq_acc;
    logic [PTR_W-1:0]  n_deq;
    logic              do_enq;

    // Number of offered enqueue lanes.
    always_comb begin
        n_enq = '0;
        for (int i = 0; i < ENQ_W; i++) begin
            n_enq = n_enq + PTR_W'(enq_valid[i]);
        end
    end

    // Number of lanes actually consumed; taking an invalid lane is ignored.
    always_comb begin
        n_deq = '0;
        for (int i = 0; i < DEQ_W; i++) begin
            n_deq = n_deq + PTR_W'(deq_take[i] & deq_valid[i]);
        end
    end

    // Readiness uses the pre-dequeue count; same-cycle frees are not credited.
    assign enq_ready = (PTR_W'(DEPTH) - count) >= PTR_W'(ENQ_W);
    assign do_enq    = enq_ready && (n_enq != '0) && !flush;
    assign n_enq_acc = do_enq ? n_enq : '0;

    assign full  = (count == PTR_W'(DEPTH));
    assign empty = (count == '0);

    // Show-ahead read port.
    always_comb begin
        deq_valid = '0;
        deq_data  = '0;
        for (int i = 0; i < DEQ_W; i++) begin
            deq_valid[i]                   = PTR_W'(i) < count;
            deq_data[i*DATA_W +: DATA_W]   = mem[IDX_W'(head + PTR_W'(i))];
        end
    end

    // Pointer and occupancy registers; flush has priority over enq/deq.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + n_deq;
            tail  <= tail + n_enq_acc;
            count <= count + n_enq_acc - n_deq;
        end
    end

    // Storage is not reset; only accepted lanes write.
    always_ff @(posedge clk) begin
        if (!rst && do_enq) begin
            for (int i = 0; i < ENQ_W; i++) begin
                if (enq_valid[i]) begin
                    mem[IDX_W'(tail + PTR_W'(i))] <= enq_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Lane masks must be contiguous from lane 0 (v & (v+1) == 0).
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((enq_valid & ENQ_W'(enq_valid + ENQ_W'(1))) == '0);
            assert ((deq_take & DEQ_W'(deq_take + DEQ_W'(1))) == '0);
            assert (count <= PTR_W'(DEPTH));
        end
    end

endmodule
